// File: rtl/bcd_scan_mux.sv
// Multiplexed BCD scanner for common-anode 7-segment displays: frame-aligned
// double buffering, leading-zero blanking and a per-slot anti-ghosting dead time.
module bcd_scan_mux #(
  parameter int         N_DIGITS   = 4,
  parameter int         PRESCALE   = 100000,
  parameter int         DEAD       = 2,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  input  logic                        blank_lz,
  output logic [3:0]                  digit_out,
  output logic [N_DIGITS-1:0]         anode_sel,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(PRESCALE - 1);

  logic [4*N_DIGITS-1:0] shadow;
  logic [4*N_DIGITS-1:0] display;
  logic                  pending;
  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  wrap_q;

  logic                  slot_end;
  logic                  frame_wrap;
  logic                  in_dead;
  logic                  zero_above;
  logic [3:0]            disp_nib [N_DIGITS];
  logic [N_DIGITS-1:0]   blank;
  logic [N_DIGITS-1:0]   anode_nxt;
  logic [3:0]            digit_nxt;

  assign slot_end   = enable && (pcnt == LAST_CNT);
  assign frame_wrap = slot_end && (idx == LAST_IDX);

  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      assign in_dead = (pcnt < PW'(DEAD));
    end
  endgenerate

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    assign disp_nib[g] = display[4*g +: 4];
  end

  // Slot timer and digit index; both freeze while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (enable) begin
      if (pcnt == LAST_CNT) begin
        pcnt <= '0;
        idx  <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // A load landing on the boundary edge stays pending; the transfer uses the older shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (frame_wrap && pending) begin
        display <= shadow;
      end
      if (load) begin
        shadow  <= digits_in;
        pending <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Digit k is blank when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_nib[k] == 4'd0);
      blank[k]   = blank_lz && zero_above;
    end
  end

  always_comb begin
    anode_nxt = '1;
    digit_nxt = BLANK_CODE;
    if (enable && !in_dead) begin
      anode_nxt = ~(N_DIGITS'(1) << idx);
      digit_nxt = blank[idx] ? BLANK_CODE : disp_nib[idx];
    end
  end

  // frame_done is delayed one extra stage so it coincides with digit_idx showing 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode_sel  <= '1;
      digit_out  <= BLANK_CODE;
      digit_idx  <= '0;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      anode_sel  <= anode_nxt;
      digit_out  <= digit_nxt;
      digit_idx  <= idx;
      wrap_q     <= frame_wrap;
      frame_done <= wrap_q;
    end
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux (N_DIGITS=4, PRESCALE=4, DEAD=1): stimulus queues
// hand-computed per-slot codes, a negedge monitor checks each lit slot as it appears.
module tb_bcd_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  digit_out;
  logic [3:0]  anode_sel;
  logic [1:0]  digit_idx;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] anode;
    logic [3:0] digit;
    logic [1:0] idx;
  } slot_t;

  slot_t      exp_q[$];
  bit         mon_on = 1'b0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] prev_an = 4'hF;
  int         run_len = 0;
  bit         armed = 1'b0;
  logic [3:0] anode_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  bcd_scan_mux #(
    .N_DIGITS(4), .PRESCALE(4), .DEAD(1), .BLANK_CODE(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .digits_in(digits_in), .blank_lz(blank_lz), .digit_out(digit_out),
    .anode_sel(anode_sel), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] value);
    digits_in = value;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits for a frame_done cycle (or uses the current one) and scoreboards that frame.
  task automatic check_frame(input logic [15:0] exp_codes);
    int    waited = 0;
    int    extra = 0;
    slot_t s;
    while (frame_done !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("frame_done seen", frame_done, 1'b1);
    if (frame_done !== 1'b1) return;
    checkOutput("frame_done aligned idx", digit_idx, 2'd0);
    for (int k = 0; k < 4; k++) begin
      s.anode = anode_tbl[k];
      s.digit = exp_codes[4*k +: 4];
      s.idx   = 2'(k);
      exp_q.push_back(s);
    end
    mon_on = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (frame_done) extra++;
    end
    @(negedge clk);
    mon_on = 1'b0;
    checkOutput("frame_done extra pulses", extra, 0);
    checkOutput("frame period 16", frame_done, 1'b1);
    checkOutput("scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: pops one expected record at every slot start and checks the lit length.
  initial begin : monitor
    slot_t e;
    forever begin
      @(negedge clk);
      if (anode_sel != 4'hF) begin
        if (prev_an == 4'hF) begin
          run_len = 0;
          if (mon_on) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("[TB] FAIL unexpected slot: got anode %b expected none", anode_sel);
            end else begin
              e = exp_q.pop_front();
              checkOutput("slot anode", anode_sel, e.anode);
              checkOutput("slot digit", digit_out, e.digit);
              checkOutput("slot idx", digit_idx, e.idx);
              armed = 1'b1;
            end
          end
        end
        run_len++;
      end else if (prev_an != 4'hF && armed) begin
        checkOutput("slot lit cycles", run_len, 3);
        armed = 1'b0;
      end
      prev_an = anode_sel;
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int w;
    int blank_bad;

    // Reset held with scanning enabled
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset anode", anode_sel, 4'b1111);
    checkOutput("reset digit", digit_out, 4'hF);
    checkOutput("reset frame_done", frame_done, 1'b0);
    checkOutput("reset idx", digit_idx, 2'd0);
    rst_n = 1'b1;
    w = 0;
    while (anode_sel === 4'hF && w < 10) begin
      @(negedge clk);
      w++;
    end
    checkOutput("first lit anode", anode_sel, 4'b1110);
    checkOutput("first lit digit", digit_out, 4'h0);
    checkOutput("first lit cycle", w, 2);

    // Basic scan
    applyStimulus(16'h1234);
    check_frame(16'h1234);
    check_frame(16'h1234);

    // Leading-zero blanking
    blank_lz = 1'b1;
    applyStimulus(16'h0050);
    check_frame(16'hFF50);
    applyStimulus(16'h0000);
    check_frame(16'hFFF0);
    blank_lz = 1'b0;
    check_frame(16'h0000);

    // Mid-frame loads: last one wins, shown only from the next frame
    repeat (4) @(negedge clk);
    applyStimulus(16'h1111);
    @(negedge clk);
    applyStimulus(16'h2222);
    w = 0;
    while (anode_sel !== 4'b0111 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("old frame kept", digit_out, 4'h0);
    check_frame(16'h2222);

    // Load coincident with the boundary edge is deferred one frame
    applyStimulus(16'h4444);
    repeat (13) @(negedge clk);
    applyStimulus(16'h5555);
    check_frame(16'h4444);
    check_frame(16'h5555);

    // Enable pause in slot 2
    repeat (9) @(negedge clk);
    checkOutput("pre-pause anode", anode_sel, 4'b1011);
    enable = 1'b0;
    blank_bad = 0;
    w = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (anode_sel !== 4'hF || digit_out !== 4'hF) blank_bad++;
      if (frame_done) w++;
    end
    checkOutput("pause outputs dark", blank_bad, 0);
    checkOutput("pause frame_done", w, 0);
    checkOutput("pause idx held", digit_idx, 2'd2);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("resume anode", anode_sel, 4'b1011);
    checkOutput("resume digit", digit_out, 4'h5);
    @(negedge clk);
    checkOutput("resume held pcnt lit", anode_sel, 4'b1011);
    @(negedge clk);
    checkOutput("resume dead", anode_sel, 4'b1111);
    @(negedge clk);
    checkOutput("resume slot3", anode_sel, 4'b0111);
    repeat (3) @(negedge clk);
    checkOutput("resume frame_done", frame_done, 1'b1);

    // Asynchronous reset with a load pending
    applyStimulus(16'h9999);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset lit", anode_sel, 4'b1110);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset anode", anode_sel, 4'b1111);
    checkOutput("async reset digit", digit_out, 4'hF);
    checkOutput("async reset idx", digit_idx, 2'd0);
    checkOutput("async reset frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
